pattern_chk_lane: RTL and testbench
===================================

// Module: pattern_chk_lane
// PURPOSE
//  Parametrised per-lane receive checker for XCVR loopback/link tests: comma-aligns, self-seeds a
//  counter pattern, checks every valid data word, keeps a saturating error count, and pulses a PCS
//  lane reset on repeated 8b10b disparity/code violations. One instance per lane; outputs go to UART.
// PARAMETERS
//  g_DATA_WID     32  data width, multiple of 8 (8..64); g_K_WID = g_DATA_WID/8 (derived localparam)
//  g_SYNC_CNT     4   consecutive comma words required before data seeding (1..15)
//  g_LOSS_CNT     4   consecutive mismatching data words that drop lock (1..15)
//  g_ERRC_WID     32  error counter width
//  g_PCS_ERR_THR  3   PCS reset fires when error-cycle count > this value within a 256-cycle window
//  g_PCS_RST_LEN  4   lane_arst_n_o low-pulse length, cycles (1..15)
// PORTS
//  clk_i          in   1           RX parallel clock
//  ARST_N         in   1           reset, asynchronous, active-low
//  start_i        in   1           async; 2-FF synced; high = output snapshot registers update
//  clear_i        in   1           async; 2-FF synced; high = clear error count/flag
//  inj_err_i      in   1           TX error injection active; suppresses PCS-reset detection
//  rx_ready_i     in   1           XCVR RX ready
//  rx_val_i       in   1           RX word valid
//  data_in_i      in   g_DATA_WID  RX data
//  rx_k_i         in   g_K_WID     K-char flags, bit n = byte n
//  disp_err_i     in   g_K_WID     disparity error per byte
//  lcv_err_i      in   g_K_WID     code violation per byte
//  lane_arst_n_o  out  1           PCS lane reset, active-low
//  error_count_o  out  g_ERRC_WID  error count snapshot
//  error_o        out  1           sticky error flag snapshot
//  lock_o         out  1           lock snapshot
//  rx_val_o       out  1           rx_val_i snapshot
// BEHAVIOUR
//  Reset: all outputs 0 except lane_arst_n_o=1; FSM=HUNT; error count 0; sticky error 1 (internal).
//  Comma word: rx_val_i & rx_k_i==1 (byte0 only) & data_in_i=={zeros,8'hBC}. Non-valid cycles hold all state.
//  FSM (advances only on rx_val_i=1):
//   HUNT : comma -> ALIGN, comma counter=1 (g_SYNC_CNT=1: straight to SEED).
//   ALIGN: comma -> counter+1, ->SEED when counter reaches g_SYNC_CNT; non-comma -> HUNT, counter=0.
//   SEED : further commas stay; rx_k_i==0 -> expected=data_in_i+1 (mod 2^W), ->LOCK. Seed word unchecked.
//          Any other K pattern (rx_k_i!=0 and not comma) -> HUNT.
//   LOCK : rx_k_i!=0 -> word ignored, expected held. rx_k_i==0 -> compare to expected; expected+=1
//          regardless of result (wraps all-ones->0). Match: miss counter=0. Mismatch: error count+1,
//          sticky error=1, miss counter+1; reaching g_LOSS_CNT -> HUNT.
//  Internal lock=1 only in LOCK. Error count also +1 per valid word while not in LOCK
//   (counts unaligned time); saturates at all-ones, never wraps.
//  Sticky error: set on any count increment; cleared only by synced clear_i.
//  clear (synced) wins over a same-cycle increment: count=0, sticky=0; FSM unaffected.
//  Snapshot: while synced start=1, outputs <= internal {count, sticky, lock, rx_val_i} each cycle
//   (1-cycle latency from internal); start=0 freezes outputs.
//  PCS reset: window counter 0..255 runs while rx_ready_i & !inj_err_i, else held at 0.
//   Error-cycle counter +1 on cycles with rx_ready_i & (|disp_err_i | |lcv_err_i); cleared at window
//   wrap, when !rx_ready_i, inj_err_i, or lane_arst_n_o=0. Count > g_PCS_ERR_THR -> lane_arst_n_o
//   low exactly g_PCS_RST_LEN cycles starting next cycle, then counters restart from 0.
//   While lane_arst_n_o=0 the FSM is forced to HUNT, and the miss and comma counters are cleared.
// CONFIGURATION
//  PATCHK_BITERR_EN defined: a mismatch adds popcount(data_in_i ^ expected) (bit errors) to the
//   count, saturating; unaligned words add g_DATA_WID. Undefined: +1 per erroneous word (as above).
// TESTING
//  4 commas, then 0x10,0x11,0x12 with start=1 -> lock_o=1 by the 3rd data word, error_count_o=0.
//  Locked, corrupt one word (0x13->0x93) -> count +1 (BITERR_EN: +1), error_o=1, lock_o stays 1.
//  Locked, 4 consecutive bad words -> FSM HUNT, lock_o=0; re-send 4 commas + data -> relock.
//  Seed 0xFFFFFFFE, then 0xFFFFFFFF, 0x00000000 -> no errors (wrap); K word mid-stream ignored.
//  disp_err_i=1 on 4 cycles inside a window, rx_ready=1 -> lane_arst_n_o low exactly 4 cycles;
//   repeat with inj_err_i=1 -> no pulse.
//  Force count to all-ones -> holds; clear_i pulse -> count 0, error_o 0 after sync+snapshot.

Source files
------------

// File: rtl/pattern_chk_lane.sv
// pattern_chk_lane: per-lane RX comma aligner, counter-pattern checker and PCS lane-reset generator.
// Build option PATCHK_BITERR_EN: mismatches add bit-error counts (unaligned words add g_DATA_WID).
module pattern_chk_lane #(
    parameter int g_DATA_WID    = 32,
    parameter int g_SYNC_CNT    = 4,
    parameter int g_LOSS_CNT    = 4,
    parameter int g_ERRC_WID    = 32,
    parameter int g_PCS_ERR_THR = 3,
    parameter int g_PCS_RST_LEN = 4
) (
    input  logic                    clk_i,
    input  logic                    ARST_N,
    input  logic                    start_i,
    input  logic                    clear_i,
    input  logic                    inj_err_i,
    input  logic                    rx_ready_i,
    input  logic                    rx_val_i,
    input  logic [g_DATA_WID-1:0]   data_in_i,
    input  logic [g_DATA_WID/8-1:0] rx_k_i,
    input  logic [g_DATA_WID/8-1:0] disp_err_i,
    input  logic [g_DATA_WID/8-1:0] lcv_err_i,
    output logic                    lane_arst_n_o,
    output logic [g_ERRC_WID-1:0]   error_count_o,
    output logic                    error_o,
    output logic                    lock_o,
    output logic                    rx_val_o
);
    localparam int g_K_WID = g_DATA_WID / 8;

    typedef enum logic [1:0] {HUNT, ALIGN, SEED, LOCK} state_t;

    state_t                state_q, state_d;
    logic [3:0]            comma_q, comma_d, miss_q, miss_d;
    logic [g_DATA_WID-1:0] exp_q, exp_d;
    logic [g_ERRC_WID-1:0] cnt_q, cnt_d, inc;
    logic [g_ERRC_WID:0]   sum;
    logic                  sticky_q, sticky_d, err_word;
    logic [1:0]            start_sync_q, clear_sync_q;
    logic [7:0]            win_q, win_d;
    logic [8:0]            ecyc_q, ecyc_d, ecyc_inc;
    logic [3:0]            rst_cnt_q, rst_cnt_d;
    logic                  lane_q, lane_d, fire, pcs_run;
    logic                  is_comma, k_zero, clr;
    logic [g_ERRC_WID-1:0] cnt_out_q;
    logic                  err_out_q, lock_out_q, val_out_q;

    assign is_comma = (rx_k_i == g_K_WID'(1)) && (data_in_i == g_DATA_WID'(8'hBC));
    assign k_zero   = (rx_k_i == '0);
    assign clr      = clear_sync_q[1];

    always_comb begin
        state_d  = state_q;
        comma_d  = comma_q;
        miss_d   = miss_q;
        exp_d    = exp_q;
        err_word = 1'b0;
`ifdef PATCHK_BITERR_EN
        inc      = g_ERRC_WID'(g_DATA_WID);
`else
        inc      = g_ERRC_WID'(1);
`endif
        if (rx_val_i) begin
            err_word = (state_q != LOCK);
            case (state_q)
                HUNT: if (is_comma) begin
                    comma_d = 4'd1;
                    state_d = (g_SYNC_CNT == 1) ? SEED : ALIGN;
                end
                ALIGN: if (is_comma) begin
                    comma_d = comma_q + 4'd1;
                    if (comma_q + 4'd1 == 4'(g_SYNC_CNT))
                        state_d = SEED;
                end else begin
                    comma_d = '0;
                    state_d = HUNT;
                end
                SEED: if (k_zero) begin
                    exp_d   = data_in_i + g_DATA_WID'(1);
                    state_d = LOCK;
                end else if (!is_comma) begin
                    comma_d = '0;
                    state_d = HUNT;
                end
                LOCK: if (k_zero) begin
                    exp_d = exp_q + g_DATA_WID'(1);
                    if (data_in_i == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_word = 1'b1;
`ifdef PATCHK_BITERR_EN
                        inc      = g_ERRC_WID'($countones(data_in_i ^ exp_q));
`endif
                        miss_d   = miss_q + 4'd1;
                        if (miss_q + 4'd1 == 4'(g_LOSS_CNT)) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // PCS lane reset in progress: realign from scratch afterwards
        if (!lane_q) begin
            state_d = HUNT;
            comma_d = '0;
            miss_d  = '0;
        end
    end

    assign sum      = {1'b0, cnt_q} + {1'b0, inc};
    assign cnt_d    = clr ? '0 : err_word ? (sum[g_ERRC_WID] ? '1 : sum[g_ERRC_WID-1:0]) : cnt_q;
    assign sticky_d = clr ? 1'b0 : (sticky_q | err_word);

    assign pcs_run   = rx_ready_i & ~inj_err_i & lane_q;
    assign ecyc_inc  = ecyc_q + 9'(rx_ready_i & (|disp_err_i | |lcv_err_i));
    assign fire      = pcs_run && (int'(ecyc_inc) > g_PCS_ERR_THR);
    assign win_d     = (pcs_run && !fire) ? win_q + 8'd1 : '0;
    assign ecyc_d    = (!pcs_run || fire || win_q == 8'hFF) ? '0 : ecyc_inc;
    assign rst_cnt_d = fire ? 4'(g_PCS_RST_LEN) : (rst_cnt_q != '0) ? rst_cnt_q - 4'd1 : '0;
    assign lane_d    = !fire && (rst_cnt_q <= 4'd1);

    always_ff @(posedge clk_i or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= HUNT;
            comma_q      <= '0;
            miss_q       <= '0;
            exp_q        <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b1;
            start_sync_q <= '0;
            clear_sync_q <= '0;
            win_q        <= '0;
            ecyc_q       <= '0;
            rst_cnt_q    <= '0;
            lane_q       <= 1'b1;
            cnt_out_q    <= '0;
            err_out_q    <= 1'b0;
            lock_out_q   <= 1'b0;
            val_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            comma_q      <= comma_d;
            miss_q       <= miss_d;
            exp_q        <= exp_d;
            cnt_q        <= cnt_d;
            sticky_q     <= sticky_d;
            start_sync_q <= {start_sync_q[0], start_i};
            clear_sync_q <= {clear_sync_q[0], clear_i};
            win_q        <= win_d;
            ecyc_q       <= ecyc_d;
            rst_cnt_q    <= rst_cnt_d;
            lane_q       <= lane_d;
            if (start_sync_q[1]) begin
                cnt_out_q  <= cnt_q;
                err_out_q  <= sticky_q;
                lock_out_q <= (state_q == LOCK);
                val_out_q  <= rx_val_i;
            end
        end
    end

    assign lane_arst_n_o = lane_q;
    assign error_count_o = cnt_out_q;
    assign error_o       = err_out_q;
    assign lock_o        = lock_out_q;
    assign rx_val_o      = val_out_q;
endmodule

// File: tb/tb_pattern_chk_lane.sv
// tb_pattern_chk_lane: scoreboard bench for pattern_chk_lane (8-bit error counter to reach saturation).
module tb_pattern_chk_lane;
    localparam int W  = 32;
    localparam int KW = 4;
    localparam int EW = 8;
`ifdef PATCHK_BITERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic          clk_i = 1'b0, ARST_N = 1'b0;
    logic          start_i = 1'b0, clear_i = 1'b0, inj_err_i = 1'b0, rx_ready_i = 1'b0, rx_val_i = 1'b0;
    logic [W-1:0]  data_in_i = '0;
    logic [KW-1:0] rx_k_i = '0, disp_err_i = '0, lcv_err_i = '0;
    logic          lane_arst_n_o, error_o, lock_o, rx_val_o;
    logic [EW-1:0] error_count_o;

    always #5 clk_i = ~clk_i;

    pattern_chk_lane #(.g_DATA_WID(W), .g_SYNC_CNT(4), .g_LOSS_CNT(4), .g_ERRC_WID(EW),
                       .g_PCS_ERR_THR(3), .g_PCS_RST_LEN(4)) dut (
        .clk_i(clk_i), .ARST_N(ARST_N), .start_i(start_i), .clear_i(clear_i),
        .inj_err_i(inj_err_i), .rx_ready_i(rx_ready_i), .rx_val_i(rx_val_i),
        .data_in_i(data_in_i), .rx_k_i(rx_k_i), .disp_err_i(disp_err_i), .lcv_err_i(lcv_err_i),
        .lane_arst_n_o(lane_arst_n_o), .error_count_o(error_count_o), .error_o(error_o),
        .lock_o(lock_o), .rx_val_o(rx_val_o)
    );

    typedef struct packed {
        int            due;
        logic [EW-1:0] cnt;
        logic          err;
        logic          lock;
        logic          rv;
    } exp_t;

    exp_t         sb[$];
    string        sb_tag[$];
    int           n_tests = 0, n_fail = 0, cyc = 0;
    int           m_st = 0, m_cc = 0, m_miss = 0, m_cnt = 0;
    logic [W-1:0] m_exp = '0;
    bit           m_sticky = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic m_add(input int n);
        m_cnt    = (m_cnt + n > 255) ? 255 : m_cnt + n;
        m_sticky = 1'b1;
    endtask

    // Reference behaviour of the aligner/checker for one sampled word
    task automatic m_step(input bit v, input logic [KW-1:0] k, input logic [W-1:0] d);
        bit comma;
        comma = (k == 4'b0001) && (d == 32'hBC);
        if (!v) return;
        if (m_st != 3) m_add(BE ? W : 1);
        case (m_st)
            0: if (comma) begin m_cc = 1; m_st = 1; end
            1: if (comma) begin m_cc++; if (m_cc == 4) m_st = 2; end else begin m_cc = 0; m_st = 0; end
            2: if (k == 0) begin m_exp = d + 1; m_st = 3; end else if (!comma) m_st = 0;
            default: if (k == 0) begin
                if (d !== m_exp) begin
                    m_add(BE ? $countones(d ^ m_exp) : 1);
                    m_miss++;
                    if (m_miss == 4) begin m_miss = 0; m_st = 0; end
                end else m_miss = 0;
                m_exp = m_exp + 1;
            end
        endcase
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, ".cnt"},  error_count_o, e.cnt);
            check({t, ".err"},  error_o,       e.err);
            check({t, ".lock"}, lock_o,        e.lock);
            check({t, ".rv"},   rx_val_o,      e.rv);
        end
    endtask

    task automatic drv(input bit v, input logic [KW-1:0] k, input logic [W-1:0] d);
        @(negedge clk_i);
        rx_val_i  = v;
        rx_k_i    = k;
        data_in_i = d;
        @(posedge clk_i);
        m_step(v, k, d);
        cyc++;
        #1;
        drain();
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, '0, '0);
    endtask

    task automatic wrd(input logic [W-1:0] d);
        drv(1'b1, '0, d);
    endtask

    task automatic commas(input int n);
        repeat (n) drv(1'b1, 4'b0001, 32'hBC);
    endtask

    task automatic push(input string tag, input bit rv);
        sb.push_back('{due: cyc + 1, cnt: EW'(m_cnt), err: m_sticky, lock: (m_st == 3), rv: rv});
        sb_tag.push_back(tag);
    endtask

    task automatic snap(input string tag);
        push(tag, 1'b0);
        idle(1);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        idle(3);
        clear_i = 1'b0;
        idle(3);
        m_cnt    = 0;
        m_sticky = 1'b0;
    endtask

    task automatic pcs_burst(input int n, input bit inj, output int lows, output int first);
        inj_err_i  = inj;
        rx_ready_i = 1'b0;
        idle(1);
        rx_ready_i = 1'b1;
        disp_err_i = 4'b0001;
        idle(n);
        disp_err_i = '0;
        lows  = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            if (!lane_arst_n_o) begin
                lows++;
                if (first < 0) first = i;
            end
            idle(1);
        end
        inj_err_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, first;
        start_i    = 1'b1;
        rx_ready_i = 1'b1;
        #22;
        check("rst.lane", lane_arst_n_o, 1);
        check("rst.cnt",  error_count_o, 0);
        check("rst.err",  error_o,       0);
        check("rst.lock", lock_o,        0);
        check("rst.rv",   rx_val_o,      0);
        ARST_N = 1'b1;
        idle(3);
        snap("sticky_rst");

        commas(4);
        wrd(32'h10);
        wrd(32'h11);
        push("lock_3rd", 1'b1);
        wrd(32'h12);
        snap("locked");
        do_clear();
        snap("clear");

        wrd(32'h93);
        wrd(32'h14);
        snap("corrupt");
        push("k_mid", 1'b1);
        drv(1'b1, 4'b0001, 32'hBC);
        wrd(32'h15);
        snap("k_after");

        repeat (3) wrd(32'hDEAD0000);
        snap("miss3");
        wrd(32'hDEAD0000);
        snap("loss");

        commas(2);
        wrd(32'h55);
        snap("align_brk");
        commas(4);
        wrd(32'hFFFFFFFE);
        wrd(32'hFFFFFFFF);
        wrd(32'h00000000);
        wrd(32'h00000001);
        snap("wrap");

        pcs_burst(3, 1'b0, lows, first);
        check("pcs_thr.lows", lows, 0);
        pcs_burst(4, 1'b0, lows, first);
        check("pcs.lows",  lows,  4);
        check("pcs.first", first, 0);
        m_st = 0; m_cc = 0; m_miss = 0;
        snap("pcs_hunt");
        pcs_burst(4, 1'b1, lows, first);
        check("pcs_inj.lows", lows, 0);

        repeat (300) wrd(32'h0);
        snap("sat");
        repeat (5) wrd(32'h0);
        snap("sat_hold");
        do_clear();
        snap("sat_clr");

        idle(2);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
